traffic_display_driver: RTL and testbench
=========================================

TRAFFIC_DISPLAY_DRIVER -- requirements
Module: traffic_display_driver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000: clock frequency in Hz, for documentation only.
REQ-002 SHALL have parameter COUNT_BITS, default 8: countdown width; legal range 4..9, so the maximum value 511 fits in 3 BCD digits.
REQ-003 SHALL have parameter SCAN_DIV, default 50: clk cycles per digit during display scan; legal minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port current_count, input, COUNT_BITS bits: remaining seconds from the countdown controller.
REQ-007 SHALL have port highway_gry, input, 3 bits: highway lamp, one-hot {G,R,Y}.
REQ-008 SHALL have port country_gry, input, 3 bits: country lamp, one-hot {G,R,Y}.
REQ-009 SHALL have port seg_n, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL have port an_n, output, 4 bits: active-low digit enables; an_n[0] is the ones digit.
REQ-011 SHALL have port highway_led, output, 3 bits: registered lamp drive.
REQ-012 SHALL have port country_led, output, 3 bits: registered lamp drive.
REQ-013 SHALL have port fault, output, 1 bit: sticky illegal-lamp-state flag.

Function
REQ-014 SHALL register current_count, highway_gry and country_gry once per clk before any use.
REQ-015 SHALL run a converter FSM IDLE -> SHIFT -> DONE -> IDLE, using sequential double-dabble at one bit per cycle for COUNT_BITS cycles.
REQ-016 SHALL leave IDLE only when registered count != last_converted.
REQ-017 SHALL, in DONE, update the 12-bit bcd_hold and last_converted atomically in one cycle.
REQ-018 SHALL make the change visible in bcd_hold exactly COUNT_BITS+3 clk cycles after the input edge.
REQ-019 SHALL finish a conversion in progress if count changes mid-conversion, then start a new conversion from IDLE on the next cycle.
REQ-020 SHALL display the latest value within 2*(COUNT_BITS+3) cycles of the last change.
REQ-021 SHALL run a scan counter 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->3->0.
REQ-022 SHALL drive exactly one an_n bit low, matching the digit index.
REQ-023 SHALL register seg_n and an_n together, so no mismatched digit/segment cycle occurs.
REQ-024 SHALL show ones, tens and hundreds on digit 0, 1 and 2 respectively; digit 3 SHALL always be blank (seg_n=7'h7F).
REQ-025 SHALL blank leading zeros: hundreds blank if 0; tens blank if hundreds=0 and tens=0; ones always shown, including "0".
REQ-026 SHALL treat only these {highway,country} pairs as legal: {G,R}, {Y,R}, {R,G}, {R,Y}.
REQ-027 SHALL copy the registered lamps to highway_led and country_led when a legal pair is present and fault=0, with 2-cycle latency from input.
REQ-028 SHALL set fault on any illegal registered pair, including both green, non-one-hot values and all-zero, and keep it set until rst.
REQ-029 SHALL, while fault=1, force highway_led=country_led=RED (3'b010) and make every displayed digit 0-2 show "-" (seg_n=7'b0111111).
REQ-030 SHALL continue scanning while fault=1.

Reset
REQ-031 SHALL, on rst assertion, asynchronously set: seg_n=7'h7F, an_n=4'hF, highway_led=country_led=3'b000, fault=0.
REQ-032 SHALL, on rst assertion, clear bcd_hold, last_converted, digit index and scan counter, and put the converter in IDLE.
REQ-033 SHALL abort a mid-conversion or mid-scan on rst with no partial update of bcd_hold.
REQ-034 SHALL show "0" on digit 0 from the first scan slot after rst deasserts, with count=0 and no conversion run.

Structure
REQ-035 SHALL place GREEN=3'b100, RED=3'b010 and YELLOW=3'b001, the 7-segment patterns for 0-9, blank and dash, and the legal-pair constants in shared package traffic_pkg.
REQ-036 SHALL implement the converter as sub-module bin2bcd_seq with ports clk, rst, start, bin, busy, done, bcd[11:0].
REQ-037 SHALL implement the scan, blanking and lamp-check logic in traffic_display_driver itself.

Verification
REQ-038 SHALL cover: count 8'd10 after reset -> bcd_hold=12'h010 exactly 11 cycles later; digit 2 blank; digit 1 shows "1"; digit 0 shows "0".
REQ-039 SHALL cover: count 8'd255 -> digits "2","5","5"; each an_n low for SCAN_DIV=50 cycles in order 0,1,2,3.
REQ-040 SHALL cover: count 3 -> 200 changed on the 4th SHIFT cycle -> bcd_hold becomes 12'h003, then 12'h200; no other intermediate value.
REQ-041 SHALL cover: lamps {G,R} -> {Y,R} -> {R,G} -> {R,Y} -> leds follow with 2-cycle latency; fault stays 0.
REQ-042 SHALL cover: {G,G} for 1 cycle, then legal -> fault=1 permanently; leds=RED/RED; dashes shown; rst clears all.
REQ-043 SHALL cover: rst pulse mid-conversion of 8'd99 -> immediate reset values; after release, "0" is shown and 99 converts once.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared lamp encodings, legal lamp pairs and 7-segment patterns
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] RED    = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;

    // {highway, country} lamp pairs that may legally appear together
    localparam logic [5:0] c_PAIR_GR = {GREEN,  RED};
    localparam logic [5:0] c_PAIR_YR = {YELLOW, RED};
    localparam logic [5:0] c_PAIR_RG = {RED,    GREEN};
    localparam logic [5:0] c_PAIR_RY = {RED,    YELLOW};

    // Active-low segments {g,f,e,d,c,b,a}
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
    localparam logic [6:0] c_SEG_0     = 7'h40;
    localparam logic [6:0] c_SEG_1     = 7'h79;
    localparam logic [6:0] c_SEG_2     = 7'h24;
    localparam logic [6:0] c_SEG_3     = 7'h30;
    localparam logic [6:0] c_SEG_4     = 7'h19;
    localparam logic [6:0] c_SEG_5     = 7'h12;
    localparam logic [6:0] c_SEG_6     = 7'h02;
    localparam logic [6:0] c_SEG_7     = 7'h78;
    localparam logic [6:0] c_SEG_8     = 7'h00;
    localparam logic [6:0] c_SEG_9     = 7'h10;

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = c_SEG_0;
            4'd1:    seg = c_SEG_1;
            4'd2:    seg = c_SEG_2;
            4'd3:    seg = c_SEG_3;
            4'd4:    seg = c_SEG_4;
            4'd5:    seg = c_SEG_5;
            4'd6:    seg = c_SEG_6;
            4'd7:    seg = c_SEG_7;
            4'd8:    seg = c_SEG_8;
            4'd9:    seg = c_SEG_9;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic is_legal_pair(input logic [5:0] pair);
        return (pair == c_PAIR_GR) || (pair == c_PAIR_YR) ||
               (pair == c_PAIR_RG) || (pair == c_PAIR_RY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter, one bit per clock
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_BITS-1:0] bin,
    output logic                busy,
    output logic                done,
    output logic [11:0]         bcd
);

    localparam int         c_SR_W      = 12 + BIN_BITS;
    localparam logic [3:0] c_LAST_STEP = 4'(BIN_BITS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [c_SR_W-1:0] r_sr;
    logic [3:0]        r_step;
    logic [11:0]       w_adj;

    // Add-3 correction on every BCD nibble that would overflow on the next shift
    always_comb begin
        w_adj = r_sr[c_SR_W-1:BIN_BITS];
        for (int i = 0; i < 3; i++) begin
            if (w_adj[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = w_adj[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_sr    <= '0;
            r_step  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_sr    <= {12'd0, bin};
                        r_step  <= '0;
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    r_sr <= {w_adj, r_sr[BIN_BITS-1:0]} << 1;
                    if (r_step == c_LAST_STEP) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state != c_ST_IDLE);
    assign done = (r_state == c_ST_DONE);
    assign bcd  = r_sr[c_SR_W-1:BIN_BITS];

endmodule
`default_nettype wire

// File: rtl/traffic_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : traffic_display_driver
// Description : Countdown 7-segment scanner and lamp driver with fault latch
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_display_driver
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000,
    parameter int COUNT_BITS = 8,
    parameter int SCAN_DIV   = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COUNT_BITS-1:0] current_count,
    input  logic [2:0]            highway_gry,
    input  logic [2:0]            country_gry,
    output logic [6:0]            seg_n,
    output logic [3:0]            an_n,
    output logic [2:0]            highway_led,
    output logic [2:0]            country_led,
    output logic                  fault
);

    localparam int                c_SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);

    if (COUNT_BITS < 4 || COUNT_BITS > 9 || SCAN_DIV < 2 || CLK_FREQ < 1) begin : g_bad_params
        $error("traffic_display_driver: illegal parameter value");
    end

    logic [COUNT_BITS-1:0] r_count;
    logic [COUNT_BITS-1:0] r_conv_val;
    logic [COUNT_BITS-1:0] r_last_conv;
    logic [2:0]            r_hw;
    logic [2:0]            r_cn;
    logic                  r_in_valid;
    logic [11:0]           r_bcd_hold;
    logic [c_SCAN_W-1:0]   r_scan;
    logic [1:0]            r_digit;

    logic        w_start;
    logic        w_busy;
    logic        w_done;
    logic [11:0] w_bcd;
    logic        w_legal;
    logic [6:0]  w_seg;
    logic [3:0]  w_an;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_hw       <= '0;
            r_cn       <= '0;
            r_in_valid <= 1'b0;
        end else begin
            r_count    <= current_count;
            r_hw       <= highway_gry;
            r_cn       <= country_gry;
            r_in_valid <= 1'b1;
        end
    end

    assign w_start = (r_count != r_last_conv) && !w_busy;

    bin2bcd_seq #(
        .BIN_BITS (COUNT_BITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (r_count),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // Value and tag move together so a display never mixes two conversions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conv_val  <= '0;
            r_last_conv <= '0;
            r_bcd_hold  <= '0;
        end else begin
            if (w_start) begin
                r_conv_val <= r_count;
            end
            if (w_done) begin
                r_bcd_hold  <= w_bcd;
                r_last_conv <= r_conv_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan  <= '0;
            r_digit <= '0;
        end else if (r_scan == c_SCAN_LAST) begin
            r_scan  <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    always_comb begin
        w_seg = c_SEG_BLANK;
        case (r_digit)
            2'd0: w_seg = seg_of(r_bcd_hold[3:0]);
            2'd1: w_seg = (r_bcd_hold[11:4] == 8'd0) ? c_SEG_BLANK : seg_of(r_bcd_hold[7:4]);
            2'd2: w_seg = (r_bcd_hold[11:8] == 4'd0) ? c_SEG_BLANK : seg_of(r_bcd_hold[11:8]);
            default: w_seg = c_SEG_BLANK;
        endcase
        if (fault && r_digit != 2'd3) begin
            w_seg = c_SEG_DASH;
        end
    end

    assign w_an = ~(4'b0001 << r_digit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= c_SEG_BLANK;
            an_n  <= 4'hF;
        end else begin
            seg_n <= w_seg;
            an_n  <= w_an;
        end
    end

    assign w_legal = is_legal_pair({r_hw, r_cn});

    // Lamp registers hold their reset value until the first real input sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            highway_led <= 3'b000;
            country_led <= 3'b000;
            fault       <= 1'b0;
        end else if (r_in_valid) begin
            if (fault || !w_legal) begin
                highway_led <= RED;
                country_led <= RED;
            end else begin
                highway_led <= r_hw;
                country_led <= r_cn;
            end
            if (!w_legal) begin
                fault <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_display_driver
// Description : Randomized self-checking bench against a behavioural model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_display_driver;

    localparam int COUNT_BITS = 8;
    localparam int SCAN_DIV   = 50;
    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] R = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [COUNT_BITS-1:0] current_count = '0;
    logic [2:0]            highway_gry = G;
    logic [2:0]            country_gry = R;
    logic [6:0]            seg_n;
    logic [3:0]            an_n;
    logic [2:0]            highway_led;
    logic [2:0]            country_led;
    logic                  fault;

    int n_checks = 0;
    int n_fail   = 0;
    int model_count = 0;
    bit model_fault = 1'b0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    traffic_display_driver #(
        .CLK_FREQ   (50_000),
        .COUNT_BITS (COUNT_BITS),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .current_count (current_count),
        .highway_gry   (highway_gry),
        .country_gry   (country_gry),
        .seg_n         (seg_n),
        .an_n          (an_n),
        .highway_led   (highway_led),
        .country_led   (country_led),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        int h, t, o;
        h = model_count / 100;
        t = (model_count / 10) % 10;
        o = model_count % 10;
        if (d == 3) return 7'h7F;
        if (model_fault) return 7'b0111111;
        if (d == 2) return (h == 0) ? 7'h7F : seg_tbl[h];
        if (d == 1) return (h == 0 && t == 0) ? 7'h7F : seg_tbl[t];
        return seg_tbl[o];
    endfunction

    function automatic bit pair_legal(input logic [2:0] h, input logic [2:0] c);
        return ($countones(h) == 1) && ($countones(c) == 1) && ((h == R) != (c == R));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_count = 0;
        model_fault = 1'b0;
        tick();
    endtask

    // One full scan frame: order, per-digit dwell time and segment content
    task automatic check_frame();
        int n, len, bad;
        logic [3:0] exp_an;
        n = 0;
        while (an_n == 4'b1110 && n < 8 * SCAN_DIV) begin tick(); n++; end
        n = 0;
        while (an_n != 4'b1110 && n < 8 * SCAN_DIV) begin tick(); n++; end
        check_eq("frame_sync", an_n, 4'b1110);
        for (int d = 0; d < 4; d++) begin
            exp_an = ~(4'b0001 << d);
            check_eq($sformatf("seg_digit%0d", d), seg_n, exp_seg(d));
            len = 0;
            bad = 0;
            while (an_n == exp_an && len < 2 * SCAN_DIV) begin
                if (seg_n !== exp_seg(d)) bad++;
                len++;
                tick();
            end
            check_eq($sformatf("dwell_digit%0d", d), len, SCAN_DIV);
            check_eq($sformatf("seg_stable%0d", d), bad, 0);
        end
    endtask

    task automatic convert_timed(input int v);
        current_count = COUNT_BITS'(v);
        repeat (COUNT_BITS + 2) tick();
        check_eq("hold_early", 32'(dut.r_bcd_hold == to_bcd(v)), 0);
        tick();
        check_eq("hold_ontime", dut.r_bcd_hold, to_bcd(v));
        model_count = v;
    endtask

    initial begin
        logic [11:0] prev;
        logic [11:0] chg_val [$];
        int          chg_at [$];
        logic [2:0]  seq_h [16];
        logic [2:0]  seq_c [16];
        logic [5:0]  pair;
        int          v;

        repeat (2) tick();
        check_eq("rst_seg", seg_n, 7'h7F);
        check_eq("rst_an", an_n, 4'hF);
        check_eq("rst_leds", {highway_led, country_led}, 6'd0);
        check_eq("rst_fault", fault, 1'b0);
        check_eq("rst_hold", dut.r_bcd_hold, 12'h000);

        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("first_slot_an", an_n, 4'b1110);
        check_eq("first_slot_zero", seg_n, 7'h40);

        convert_timed(10);
        check_frame();
        convert_timed(255);
        check_frame();

        for (int i = 0; i < 5; i++) begin
            do v = $urandom_range(0, 255); while (v == model_count || v == 3 || v == 200);
            convert_timed(v);
            check_frame();
        end

        // Count changes to 200 on the 4th shift cycle of the conversion of 3
        chg_val.delete();
        chg_at.delete();
        prev = dut.r_bcd_hold;
        current_count = 8'd3;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 5) current_count = 8'd200;
            if (dut.r_bcd_hold !== prev) begin
                chg_val.push_back(dut.r_bcd_hold);
                chg_at.push_back(k);
                prev = dut.r_bcd_hold;
            end
        end
        check_eq("midchange_count", chg_val.size(), 2);
        if (chg_val.size() == 2) begin
            check_eq("midchange_first", chg_val[0], 12'h003);
            check_eq("midchange_first_at", chg_at[0], COUNT_BITS + 3);
            check_eq("midchange_second", chg_val[1], 12'h200);
            check_eq("midchange_latency_ok", 32'(chg_at[1] - 5 <= 2 * (COUNT_BITS + 3)), 1);
        end
        model_count = 200;
        check_frame();

        // Legal lamp sequence with random dwell times
        v = 0;
        for (int s = 0; s < 4 && v < 16; s++) begin
            for (int r = $urandom_range(1, 4); r > 0 && v < 16; r--) begin
                case (s)
                    0: begin seq_h[v] = G; seq_c[v] = R; end
                    1: begin seq_h[v] = Y; seq_c[v] = R; end
                    2: begin seq_h[v] = R; seq_c[v] = G; end
                    default: begin seq_h[v] = R; seq_c[v] = Y; end
                endcase
                v++;
            end
        end
        for (int i = v; i < 16; i++) begin seq_h[i] = R; seq_c[i] = Y; end
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i >= 2) check_eq($sformatf("lamp_step%0d", i), {highway_led, country_led},
                                 {seq_h[i-2], seq_c[i-2]});
            if (i < 16) begin highway_gry = seq_h[i]; country_gry = seq_c[i]; end
        end
        check_eq("lamp_no_fault", fault, 1'b0);

        // Both green for a single cycle latches the fault
        highway_gry = G; country_gry = G;
        tick();
        highway_gry = G; country_gry = R;
        tick();
        check_eq("fault_set", fault, 1'b1);
        check_eq("fault_leds", {highway_led, country_led}, {R, R});
        model_fault = 1'b1;
        repeat (20) tick();
        check_eq("fault_sticky", fault, 1'b1);
        check_eq("fault_leds_held", {highway_led, country_led}, {R, R});
        check_frame();

        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("fault_rst_clear", fault, 1'b0);
        check_eq("fault_rst_leds", {highway_led, country_led}, 6'd0);
        check_eq("fault_rst_hold", dut.r_bcd_hold, 12'h000);
        current_count = '0;
        do_reset();
        check_eq("post_rst_zero", seg_n, 7'h40);
        repeat (2) tick();
        check_eq("post_rst_leds", {highway_led, country_led}, {G, R});

        // Single-cycle lamp pairs judged by the one-hot/one-red rule
        for (int t = 0; t < 6; t++) begin
            if (t == 0) pair = 6'b000000;
            else if (t == 1) pair = {R, R};
            else pair = 6'($urandom_range(0, 63));
            do_reset();
            highway_gry = pair[5:3]; country_gry = pair[2:0];
            tick();
            highway_gry = G; country_gry = R;
            repeat (3) tick();
            check_eq($sformatf("pair_fault_%02h", pair), fault, !pair_legal(pair[5:3], pair[2:0]));
            check_eq($sformatf("pair_leds_%02h", pair), {highway_led, country_led},
                     pair_legal(pair[5:3], pair[2:0]) ? {G, R} : {R, R});
        end

        // Reset in the middle of converting 99
        do_reset();
        current_count = 8'd99;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_seg", seg_n, 7'h7F);
        check_eq("abort_an", an_n, 4'hF);
        check_eq("abort_leds", {highway_led, country_led}, 6'd0);
        check_eq("abort_fault", fault, 1'b0);
        check_eq("abort_hold", dut.r_bcd_hold, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("abort_first_zero", seg_n, 7'h40);
        check_eq("abort_first_an", an_n, 4'b1110);
        chg_val.delete();
        prev = dut.r_bcd_hold;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (dut.r_bcd_hold !== prev) begin
                chg_val.push_back(dut.r_bcd_hold);
                prev = dut.r_bcd_hold;
            end
        end
        check_eq("abort_conv_once", chg_val.size(), 1);
        if (chg_val.size() == 1) check_eq("abort_conv_val", chg_val[0], 12'h099);
        model_count = 99;
        check_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
